vme_wb_bridge: RTL and testbench
================================

# vme_wb_bridge

Wishbone classic slave to VME-style strobe/done master bridge, placed directly upstream of the generated register banks (VMEAddr/VMERdMem/VMEWrMem/VMERdDone/VMEWrDone interface). Converts each Wishbone cycle into exactly one single-cycle read or write strobe, holds address and data stable until the bank answers, and returns ack, error or timeout to the Wishbone master. One transaction in flight; no buffering beyond the held request.

## Interface
- ADDR_WIDTH, 18, word-address width; maps to VMEAddr[ADDR_WIDTH+1:2]
- TIMEOUT, 255, cycles to wait for Done before error (1..65535)
- Clk  in  1  clock
- Rst  in  1  synchronous, active-high reset
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  ADDR_WIDTH  word address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid with wb_ack_o
- wb_ack_o  out  1  one-cycle ack
- wb_err_o  out  1  one-cycle error
- VMEAddr  out  ADDR_WIDTH  held request address
- VMEWrData  out  32  held write data
- VMERdMem  out  1  one-cycle read strobe
- VMEWrMem  out  1  one-cycle write strobe
- VMERdData  in  32  read data, valid with VMERdDone
- VMERdDone / VMEWrDone  in  1 each  completion
- VMERdError / VMEWrError  in  1 each  completion with error

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
- IDLE: on wb_cyc_i & wb_stb_i, latch wb_adr_i into VMEAddr, wb_dat_i into VMEWrData (writes only), record we; next cycle pulse VMEWrMem (we=1) or VMERdMem (we=0) high exactly one cycle; go to WR_WAIT/RD_WAIT.
- RD_WAIT: VMERdDone=1 -> capture VMERdData into wb_dat_o, go RESP with ack; VMERdError=1 (with or without Done) -> go RESP with err. WrDone/WrError ignored.
- WR_WAIT: symmetric on VMEWrDone/VMEWrError; RdDone/RdError ignored.
- RESP: wb_ack_o or wb_err_o high for this single cycle, then IDLE. New requests not sampled in RESP (master must drop stb after ack).
- Done/Error seen in IDLE or RESP: ignored.
- Abort: wb_cyc_i dropping during *_WAIT does not cancel; bridge still waits for Done/timeout, then passes through RESP with ack/err suppressed.
- VMEAddr, VMEWrData stable from strobe cycle until leaving *_WAIT; wb_dat_o holds last read value until next read completes.
- Reset values: all strobes, wb_ack_o, wb_err_o = 0; VMEAddr, VMEWrData, wb_dat_o = 0; state IDLE; timeout counter 0.
- Reset mid-transaction: return to IDLE next edge, no ack/err issued, any later Done ignored.

## Timing
- Request sampled cycle N; strobe at N+1; earliest Done at N+1 (combinational slave) -> ack/err at N+2.
- Against a registered bank: read Done at N+2 -> ack N+3; write Done at N+3 -> ack N+4.
- Throughput: at most one transaction per 3 cycles.
- Timeout counter: cleared on strobe cycle, +1 each cycle in *_WAIT; Done absent when count reaches TIMEOUT -> RESP with err. Done and timeout in same cycle: Done wins (ack). Counter width ceil(log2(TIMEOUT+1)), saturates, never wraps.

## Configuration
- VME_WB_BRIDGE_TIMEOUT_EN defined: timeout counter and timeout error path present as above.
- Undefined: no counter; *_WAIT waits indefinitely for Done/Error; TIMEOUT parameter unused.

## Test plan
- Read addr 0x00001 from bank returning 0x00010203 with Done at N+2 -> VMERdMem one pulse at N+1, wb_ack_o at N+3, wb_dat_o = 0x00010203, wb_err_o = 0.
- Write 0xDEADBEEF to addr 0x0 with Done at N+3 -> VMEWrMem one pulse, VMEWrData = 0xDEADBEEF held until Done, ack at N+4.
- No Done, TIMEOUT=16, macro defined -> wb_err_o one pulse 17 cycles after strobe; Done arriving 5 cycles later ignored, state IDLE.
- VMERdError with VMERdDone on read -> wb_err_o=1, wb_ack_o=0, wb_dat_o unchanged from previous read.
- wb_cyc_i dropped 1 cycle after strobe, Done 3 cycles later -> no ack/err on bus, next request accepted normally.
- Rst asserted one cycle in RD_WAIT, then Done -> all outputs 0, no ack; following write completes with ack.

Source files
------------

// File: rtl/vme_wb_bridge.sv
// vme_wb_bridge
// Wishbone classic slave to VME-style strobe/done master. Each Wishbone cycle
// becomes exactly one single-cycle read or write strobe toward the register
// bank. Address and write data are held until the bank answers. The result is
// returned as a one-cycle ack or err.
// Optional feature: define VME_WB_BRIDGE_TIMEOUT_EN to add the Done timeout
// counter and its error path. Without it the bridge waits indefinitely.
module vme_wb_bridge #(
  parameter int ADDR_WIDTH = 18,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_WIDTH-1:0] VMEAddr,
  output logic [31:0]           VMEWrData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic [31:0]           VMERdData,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone,
  input  logic                  VMERdError,
  input  logic                  VMEWrError
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t state;
  logic   aborted;
  logic   abort_now;
  logic   timed_out;

  // Reject an out-of-range TIMEOUT at elaboration rather than build a broken counter
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("vme_wb_bridge: TIMEOUT must lie in 1..65535");
  end

  // The master has given up on this cycle if cyc dropped now or at any earlier wait cycle
  assign abort_now = aborted | ~wb_cyc_i;

`ifdef VME_WB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] timeout_cnt;

  // Count wait cycles from the strobe; zero while idle, hold at the limit instead of wrapping
  always_ff @(posedge Clk) begin
    if (Rst) begin
      timeout_cnt <= '0;
    end else if (state == IDLE) begin
      timeout_cnt <= '0;
    end else if ((state == RD_WAIT || state == WR_WAIT) && timeout_cnt != CNT_LIMIT) begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  assign timed_out = (timeout_cnt == CNT_LIMIT);
`else
  assign timed_out = 1'b0;
`endif

  // Request/response FSM; every bus-facing output is registered here
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      aborted   <= 1'b0;
      VMERdMem  <= 1'b0;
      VMEWrMem  <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      VMEAddr   <= '0;
      VMEWrData <= '0;
      wb_dat_o  <= '0;
    end else begin
      VMERdMem <= 1'b0;
      VMEWrMem <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            VMEAddr <= wb_adr_i;
            aborted <= 1'b0;
            if (wb_we_i) begin
              VMEWrData <= wb_dat_i;
              VMEWrMem  <= 1'b1;
              state     <= WR_WAIT;
            end else begin
              VMERdMem <= 1'b1;
              state    <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          aborted <= abort_now;
          if (VMERdError) begin
            wb_err_o <= ~abort_now;
            state    <= RESP;
          end else if (VMERdDone) begin
            wb_dat_o <= VMERdData;
            wb_ack_o <= ~abort_now;
            state    <= RESP;
          end else if (timed_out) begin
            wb_err_o <= ~abort_now;
            state    <= RESP;
          end
        end
        WR_WAIT: begin
          aborted <= abort_now;
          if (VMEWrError) begin
            wb_err_o <= ~abort_now;
            state    <= RESP;
          end else if (VMEWrDone) begin
            wb_ack_o <= ~abort_now;
            state    <= RESP;
          end else if (timed_out) begin
            wb_err_o <= ~abort_now;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vme_wb_bridge.sv
// tb_vme_wb_bridge
// Self-checking bench for vme_wb_bridge. The bench plays both the Wishbone
// master and the register bank. Expected timing and data come from the
// transaction-level rules: the strobe comes one cycle after the request, and
// the response comes one cycle after Done, error or timeout.
module tb_vme_wb_bridge;

  localparam int AW = 18;
  localparam int TO = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i, wb_dat_o;
  logic          wb_ack_o, wb_err_o;
  logic [AW-1:0] VMEAddr;
  logic [31:0]   VMEWrData;
  logic          VMERdMem, VMEWrMem;
  logic [31:0]   VMERdData;
  logic          VMERdDone, VMEWrDone, VMERdError, VMEWrError;

  int checks = 0;
  int errors = 0;

  // Model of wb_dat_o: last successfully completed read value
  logic [31:0] last_rd;

  // Observations of the most recent run_txn call
  int          rd_strobes, wr_strobes, first_strobe, acks, errs, resp_ofs;
  logic [31:0] dat_at_resp;
  bit          hold_ok;

  vme_wb_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
    .VMERdError(VMERdError), .VMEWrError(VMEWrError)
  );

  always #5 Clk = ~Clk;

  // Step to just after the next rising edge, where outputs are settled
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic slave_idle();
    VMERdDone  = 1'b0;
    VMEWrDone  = 1'b0;
    VMERdError = 1'b0;
    VMEWrError = 1'b0;
    VMERdData  = $urandom;
  endtask

  // Response offset from the request cycle, as the bridge's rules dictate
  function automatic int expect_resp_ofs(input int lat);
`ifdef VME_WB_BRIDGE_TIMEOUT_EN
    if (lat < 0 || lat > TO) return TO + 2;
`endif
    if (lat < 0) return -1;
    return lat + 2;
  endfunction

  // One Wishbone transaction. The request is driven in the current cycle (t=0).
  // The bank answers lat cycles after the strobe cycle (lat<0: never).
  // The master drops cyc drop_at cycles after the strobe (drop_at<0: never).
  task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [31:0] wdat,
                         input int lat, input logic rerr, input logic [31:0] rdat,
                         input int drop_at, input int window);
    rd_strobes = 0; wr_strobes = 0; first_strobe = -1;
    acks = 0; errs = 0; resp_ofs = -1; dat_at_resp = '0; hold_ok = 1'b1;
    slave_idle();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
    for (int t = 1; t <= window; t++) begin
      tick();
      if (VMERdMem) rd_strobes++;
      if (VMEWrMem) wr_strobes++;
      if ((VMERdMem || VMEWrMem) && first_strobe < 0) first_strobe = t;
      if (wb_ack_o) acks++;
      if (wb_err_o) errs++;
      if ((wb_ack_o || wb_err_o) && resp_ofs < 0) begin
        resp_ofs    = t;
        dat_at_resp = wb_dat_o;
      end
      if (resp_ofs < 0 && (VMEAddr !== adr || (we && VMEWrData !== wdat))) hold_ok = 1'b0;
      // Scramble master address/data so a pass-through would show up on the VME side
      wb_adr_i = AW'($urandom);
      wb_dat_i = $urandom;
      // Bank side: real answer at the chosen cycle, noise on the other direction
      slave_idle();
      if (we) begin
        VMERdDone  = 1'($urandom_range(0, 1));
        VMERdError = 1'($urandom_range(0, 1));
      end else begin
        VMEWrDone  = 1'($urandom_range(0, 1));
        VMEWrError = 1'($urandom_range(0, 1));
      end
      if (lat >= 0 && t == 1 + lat) begin
        if (we) begin
          VMEWrDone  = rerr ? 1'($urandom_range(0, 1)) : 1'b1;
          VMEWrError = rerr;
        end else begin
          VMERdDone  = rerr ? 1'($urandom_range(0, 1)) : 1'b1;
          VMERdError = rerr;
          VMERdData  = rdat;
        end
      end
      if (drop_at >= 0 && t == 1 + drop_at) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
      if (resp_ofs == t) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    slave_idle();
  endtask

  // Reset clears every output
  task automatic test_reset();
    Rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
    slave_idle();
    tick();
    tick();
    checks++;
    if ({VMERdMem, VMEWrMem, wb_ack_o, wb_err_o, VMEAddr, VMEWrData, wb_dat_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rd=%b wr=%b ack=%b err=%b addr=%h wdat=%h dat=%h, required all zero",
               VMERdMem, VMEWrMem, wb_ack_o, wb_err_o, VMEAddr, VMEWrData, wb_dat_o);
    end
    Rst = 1'b0;
    last_rd = '0;
    tick();
  endtask

  // Done/Error with no transaction in flight must have no effect
  task automatic test_idle_ignored();
    int stray = 0;
    for (int k = 0; k < 4; k++) begin
      VMERdDone = 1'b1; VMEWrDone = 1'b1;
      VMERdError = 1'(k & 1); VMEWrError = 1'(k & 1);
      VMERdData = $urandom;
      tick();
      if (wb_ack_o || wb_err_o || VMERdMem || VMEWrMem) stray++;
    end
    slave_idle();
    tick();
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("[TB] FAIL idle_done_ignored: got %0d active output cycles, required 0", stray);
    end
    checks++;
    if (wb_dat_o !== last_rd) begin
      errors++;
      $display("[TB] FAIL idle_dat_hold: got %h required %h", wb_dat_o, last_rd);
    end
  endtask

  // Read against a registered bank: Done one cycle after the strobe
  task automatic test_read();
    run_txn(1'b0, 18'h00001, 32'h0, 1, 1'b0, 32'h00010203, -1, 4);
    checks++;
    if (rd_strobes !== 1 || wr_strobes !== 0 || first_strobe !== 1) begin
      errors++;
      $display("[TB] FAIL read_strobe: got rd=%0d wr=%0d at %0d, required rd=1 wr=0 at 1",
               rd_strobes, wr_strobes, first_strobe);
    end
    checks++;
    if (acks !== 1 || errs !== 0 || resp_ofs !== 3) begin
      errors++;
      $display("[TB] FAIL read_ack: got ack=%0d err=%0d at %0d, required ack=1 err=0 at 3",
               acks, errs, resp_ofs);
    end
    checks++;
    if (dat_at_resp !== 32'h00010203 || !hold_ok) begin
      errors++;
      $display("[TB] FAIL read_data: got %h hold=%0d, required 00010203 hold=1", dat_at_resp, hold_ok);
    end
    last_rd = 32'h00010203;
  endtask

  // Write with Done two cycles after the strobe; data held until then
  task automatic test_write();
    run_txn(1'b1, 18'h00000, 32'hDEADBEEF, 2, 1'b0, 32'h0, -1, 5);
    checks++;
    if (wr_strobes !== 1 || rd_strobes !== 0 || first_strobe !== 1) begin
      errors++;
      $display("[TB] FAIL write_strobe: got wr=%0d rd=%0d at %0d, required wr=1 rd=0 at 1",
               wr_strobes, rd_strobes, first_strobe);
    end
    checks++;
    if (acks !== 1 || errs !== 0 || resp_ofs !== 4) begin
      errors++;
      $display("[TB] FAIL write_ack: got ack=%0d err=%0d at %0d, required ack=1 err=0 at 4",
               acks, errs, resp_ofs);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("[TB] FAIL write_hold: got hold=0 required hold=1");
    end
  endtask

  // Error completions on both directions; read data must not move
  task automatic test_errors();
    run_txn(1'b0, AW'($urandom), 32'h0, 1, 1'b1, $urandom, -1, 4);
    checks++;
    if (errs !== 1 || acks !== 0 || resp_ofs !== 3) begin
      errors++;
      $display("[TB] FAIL rd_error: got err=%0d ack=%0d at %0d, required err=1 ack=0 at 3",
               errs, acks, resp_ofs);
    end
    checks++;
    if (wb_dat_o !== last_rd) begin
      errors++;
      $display("[TB] FAIL rd_error_dat: got %h required %h", wb_dat_o, last_rd);
    end
    run_txn(1'b1, AW'($urandom), $urandom, 0, 1'b1, 32'h0, -1, 3);
    checks++;
    if (errs !== 1 || acks !== 0 || resp_ofs !== 2) begin
      errors++;
      $display("[TB] FAIL wr_error: got err=%0d ack=%0d at %0d, required err=1 ack=0 at 2",
               errs, acks, resp_ofs);
    end
  endtask

  // Silent bank: timeout error (or indefinite wait when the counter is absent)
  task automatic test_timeout();
`ifdef VME_WB_BRIDGE_TIMEOUT_EN
    int stray = 0;
    run_txn(1'b0, AW'($urandom), 32'h0, -1, 1'b0, 32'h0, -1, TO + 3);
    checks++;
    if (errs !== 1 || acks !== 0 || resp_ofs !== TO + 2) begin
      errors++;
      $display("[TB] FAIL timeout_err: got err=%0d ack=%0d at %0d, required err=1 ack=0 at %0d",
               errs, acks, resp_ofs, TO + 2);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (wb_ack_o || wb_err_o || VMERdMem || VMEWrMem) stray++;
      VMERdDone = (k == 3);
      VMERdData = $urandom;
    end
    slave_idle();
    checks++;
    if (stray !== 0 || wb_dat_o !== last_rd) begin
      errors++;
      $display("[TB] FAIL late_done: got %0d active cycles dat=%h, required 0 dat=%h",
               stray, wb_dat_o, last_rd);
    end
    run_txn(1'b0, AW'($urandom), 32'h0, TO, 1'b0, 32'hA5A5_0F0F, -1, TO + 3);
    checks++;
    if (acks !== 1 || errs !== 0 || resp_ofs !== expect_resp_ofs(TO) || dat_at_resp !== 32'hA5A5_0F0F) begin
      errors++;
      $display("[TB] FAIL done_at_limit: got ack=%0d err=%0d at %0d dat=%h, required ack=1 err=0 at %0d dat=a5a50f0f",
               acks, errs, resp_ofs, dat_at_resp, expect_resp_ofs(TO));
    end
    last_rd = 32'hA5A5_0F0F;
    run_txn(1'b1, AW'($urandom), $urandom, TO + 1, 1'b0, 32'h0, -1, TO + 3);
    checks++;
    if (errs !== 1 || acks !== 0 || resp_ofs !== expect_resp_ofs(TO + 1)) begin
      errors++;
      $display("[TB] FAIL done_past_limit: got err=%0d ack=%0d at %0d, required err=1 ack=0 at %0d",
               errs, acks, resp_ofs, expect_resp_ofs(TO + 1));
    end
`else
    run_txn(1'b0, AW'($urandom), 32'h0, 40, 1'b0, 32'h1357_9BDF, -1, 43);
    checks++;
    if (acks !== 1 || errs !== 0 || resp_ofs !== 42 || dat_at_resp !== 32'h1357_9BDF) begin
      errors++;
      $display("[TB] FAIL long_wait: got ack=%0d err=%0d at %0d dat=%h, required ack=1 err=0 at 42 dat=13579bdf",
               acks, errs, resp_ofs, dat_at_resp);
    end
    last_rd = 32'h1357_9BDF;
`endif
  endtask

  // Master walks away mid-wait: no response on the bus, next request normal
  task automatic test_abort();
    run_txn(1'b1, AW'($urandom), $urandom, 4, 1'b0, 32'h0, 1, 8);
    checks++;
    if (acks !== 0 || errs !== 0 || wr_strobes !== 1) begin
      errors++;
      $display("[TB] FAIL abort_silent: got ack=%0d err=%0d strobes=%0d, required 0 0 1",
               acks, errs, wr_strobes);
    end
    run_txn(1'b0, AW'($urandom), 32'h0, 0, 1'b0, 32'h0BAD_F00D, -1, 3);
    checks++;
    if (acks !== 1 || resp_ofs !== 2 || dat_at_resp !== 32'h0BAD_F00D) begin
      errors++;
      $display("[TB] FAIL after_abort: got ack=%0d at %0d dat=%h, required ack=1 at 2 dat=0badf00d",
               acks, resp_ofs, dat_at_resp);
    end
    last_rd = 32'h0BAD_F00D;
  endtask

  // Reset while waiting for a read: a later Done must not produce an ack
  task automatic test_reset_mid();
    int stray = 0;
    slave_idle();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = AW'($urandom);
    tick();
    tick();
    Rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    Rst = 1'b0;
    checks++;
    if ({VMERdMem, VMEWrMem, wb_ack_o, wb_err_o, VMEAddr, VMEWrData, wb_dat_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got ack=%b err=%b addr=%h dat=%h, required all zero",
               wb_ack_o, wb_err_o, VMEAddr, wb_dat_o);
    end
    VMERdDone = 1'b1;
    VMERdData = $urandom;
    for (int k = 0; k < 3; k++) begin
      tick();
      slave_idle();
      if (wb_ack_o || wb_err_o || wb_dat_o !== 32'h0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_done: got %0d active cycles, required 0", stray);
    end
    last_rd = '0;
    run_txn(1'b1, AW'($urandom), $urandom, 1, 1'b0, 32'h0, -1, 4);
    checks++;
    if (acks !== 1 || errs !== 0 || resp_ofs !== 3) begin
      errors++;
      $display("[TB] FAIL reset_mid_write: got ack=%0d err=%0d at %0d, required ack=1 err=0 at 3",
               acks, errs, resp_ofs);
    end
  endtask

  // Combinational bank, requests issued as fast as the bridge allows
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] rd = $urandom;
      logic        we = 1'(i & 1);
      run_txn(we, AW'($urandom), $urandom, 0, 1'b0, rd, -1, 3);
      if (!we) last_rd = rd;
      checks++;
      if (acks !== 1 || resp_ofs !== 2 || first_strobe !== 1 || wb_dat_o !== last_rd) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: got ack=%0d at %0d strobe at %0d dat=%h, required 1 at 2, 1, %h",
                 i, acks, resp_ofs, first_strobe, wb_dat_o, last_rd);
      end
    end
  endtask

  // Random mix of reads/writes, latencies and error completions
  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic          we   = 1'($urandom_range(0, 1));
      logic [AW-1:0] adr  = AW'($urandom);
      logic [31:0]   wdat = $urandom;
      logic [31:0]   rdat = $urandom;
      int            lat  = $urandom_range(0, 4);
      logic          rerr = ($urandom_range(0, 4) == 0);
      run_txn(we, adr, wdat, lat, rerr, rdat, -1, lat + 3);
      if (!we && !rerr) last_rd = rdat;
      checks++;
      if (rd_strobes !== int'(!we) || wr_strobes !== int'(we) || first_strobe !== 1) begin
        errors++;
        $display("[TB] FAIL rand_strobe[%0d]: got rd=%0d wr=%0d at %0d, required rd=%0d wr=%0d at 1",
                 i, rd_strobes, wr_strobes, first_strobe, !we, we);
      end
      checks++;
      if (acks !== int'(!rerr) || errs !== int'(rerr) || resp_ofs !== expect_resp_ofs(lat)) begin
        errors++;
        $display("[TB] FAIL rand_resp[%0d]: got ack=%0d err=%0d at %0d, required ack=%0d err=%0d at %0d",
                 i, acks, errs, resp_ofs, !rerr, rerr, expect_resp_ofs(lat));
      end
      checks++;
      if (!hold_ok || wb_dat_o !== last_rd) begin
        errors++;
        $display("[TB] FAIL rand_data[%0d]: got hold=%0d dat=%h, required hold=1 dat=%h",
                 i, hold_ok, wb_dat_o, last_rd);
      end
    end
  endtask

  initial begin
    $display("[TB] vme_wb_bridge bench start");
    test_reset();
    test_idle_ignored();
    test_read();
    test_write();
    test_errors();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the run ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
